// File: rtl/daisychain_segment.sv
// Parametrised scan-chain segment with capture, bypass,
// shift-length counting and length-checked shadow update.
module daisychain_segment #(
  parameter int                    DATA_LEN     = 8,
  parameter bit                    STRICT       = 1'b1,
  parameter logic [DATA_LEN-1:0]   UPDATE_RESET = '0,
  localparam int                   CW           = $clog2(DATA_LEN+2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_in,
  input  logic                enable,
  input  logic                capture,
  input  logic                update,
  input  logic                bypass,
  input  logic [DATA_LEN-1:0] bit_in,
  output logic                data_out,
  output logic [DATA_LEN-1:0] bit_out,
  output logic [CW-1:0]       shift_count,
  output logic                len_err
);

  localparam logic [CW-1:0] LEN_C = CW'(DATA_LEN);
  localparam logic [CW-1:0] MAX_C = CW'(DATA_LEN + 1);

  logic [DATA_LEN-1:0] r_sr;
  logic [DATA_LEN-1:0] r_bit_out;
  logic [CW-1:0]       r_cnt;
  logic                r_byp;
  logic                r_len_err;
  logic                w_len_ok;

  assign w_len_ok = !STRICT || (r_cnt == LEN_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr      <= '0;
      r_byp     <= 1'b0;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
      r_bit_out <= UPDATE_RESET;
    end else if (capture) begin
      r_sr      <= bit_in;
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (update) begin
      // bypassed segments ignore update completely
      if (!bypass) begin
        r_cnt <= '0;
        if (w_len_ok) r_bit_out <= r_sr;
        else          r_len_err <= 1'b1;
      end
    end else if (enable) begin
      if (bypass) begin
        r_byp <= data_in;
      end else begin
        r_sr <= {data_in, r_sr[DATA_LEN-1:1]};
        if (r_cnt != MAX_C) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign data_out    = bypass ? r_byp : r_sr[0];
  assign bit_out     = r_bit_out;
  assign shift_count = r_cnt;
  assign len_err     = r_len_err;

endmodule

// File: tb/tb_daisychain_segment.sv
// Randomised and directed bench for daisychain_segment
// against a queue-based behavioural model.
module tb_daisychain_segment;

  localparam int L  = 8;
  localparam int CW = $clog2(L+2);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         data_in = 1'b0;
  logic         enable = 1'b0;
  logic         capture = 1'b0;
  logic         update = 1'b0;
  logic         bypass = 1'b0;
  logic [L-1:0] bit_in = '0;

  logic          data_out, data_out1;
  logic [L-1:0]  bit_out, bit_out1;
  logic [CW-1:0] shift_count, shift_count1;
  logic          len_err, len_err1;

  int total = 0;
  int bad   = 0;

  bit           mq[$];
  int           m_cnt;
  logic [L-1:0] m_bout, m1_bout;
  bit           m_err, m_byp;

  always #5 clk = ~clk;

  daisychain_segment #(
    .DATA_LEN(L), .STRICT(1'b1), .UPDATE_RESET(8'hA5)
  ) u_dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .enable(enable), .capture(capture), .update(update),
    .bypass(bypass), .bit_in(bit_in), .data_out(data_out),
    .bit_out(bit_out), .shift_count(shift_count),
    .len_err(len_err)
  );

  daisychain_segment #(
    .DATA_LEN(L), .STRICT(1'b0), .UPDATE_RESET(8'h00)
  ) u_lax (
    .clk(clk), .reset(reset), .data_in(data_in),
    .enable(enable), .capture(capture), .update(update),
    .bypass(bypass), .bit_in(bit_in), .data_out(data_out1),
    .bit_out(bit_out1), .shift_count(shift_count1),
    .len_err(len_err1)
  );

  function automatic logic [L-1:0] m_pack();
    logic [L-1:0] v;
    for (int i = 0; i < L; i++) v[i] = mq[i];
    return v;
  endfunction

  function automatic void m_reset();
    mq = {};
    for (int i = 0; i < L; i++) mq.push_back(1'b0);
    m_cnt   = 0;
    m_bout  = 8'hA5;
    m1_bout = 8'h00;
    m_err   = 1'b0;
    m_byp   = 1'b0;
  endfunction

  function automatic bit m_dout();
    return bypass ? m_byp : mq[0];
  endfunction

  task automatic step(input bit cap, input bit upd, input bit en,
                      input bit byp, input bit din,
                      input logic [L-1:0] bin);
    capture = cap; update = upd; enable = en;
    bypass = byp; data_in = din; bit_in = bin;
    @(posedge clk);
    if (cap) begin
      mq = {};
      for (int i = 0; i < L; i++) mq.push_back(bin[i]);
      m_cnt = 0;
      m_err = 1'b0;
    end else if (upd) begin
      if (!byp) begin
        if (m_cnt == L) m_bout = m_pack();
        else            m_err = 1'b1;
        m1_bout = m_pack();
        m_cnt = 0;
      end
    end else if (en) begin
      if (byp) m_byp = din;
      else begin
        mq.delete(0);
        mq.push_back(din);
        m_cnt = (m_cnt + 1 > L + 1) ? L + 1 : m_cnt + 1;
      end
    end
    #1;
  endtask

  task automatic release_reset();
    capture = 0; update = 0; enable = 0;
    bypass = 0; data_in = 0; bit_in = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    m_reset();
    release_reset();
    step(1, 0, 0, 0, 0, 8'hFF);
    for (int i = 0; i < L; i++) step(0, 0, 1, 0, 1, '0);
    step(0, 1, 0, 0, 0, '0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 m_reset();
    total += 5;
    if (bit_out !== 8'hA5) begin
      bad++; $display("FAIL reset_bit_out got=%h exp=a5", bit_out);
    end
    if (data_out !== 1'b0) begin
      bad++; $display("FAIL reset_data_out got=%b exp=0", data_out);
    end
    if (shift_count !== '0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", shift_count);
    end
    if (len_err !== 1'b0) begin
      bad++; $display("FAIL reset_len_err got=%b exp=0", len_err);
    end
    if (bit_out1 !== 8'h00) begin
      bad++; $display("FAIL reset_lax_bit_out got=%h exp=00", bit_out1);
    end
    release_reset();
  endtask

  task automatic test_full_frame();
    logic [L-1:0] oldv = 8'h5A;
    logic [L-1:0] newv = 8'h3C;
    step(1, 0, 0, 0, 0, oldv);
    for (int i = 0; i < L; i++) begin
      total++;
      if (data_out !== oldv[i]) begin
        bad++;
        $display("FAIL frame_out[%0d] got=%b exp=%b", i, data_out, oldv[i]);
      end
      step(0, 0, 1, 0, newv[i], '0);
    end
    step(0, 1, 0, 0, 0, '0);
    total += 3;
    if (bit_out !== newv) begin
      bad++; $display("FAIL frame_bit_out got=%h exp=%h", bit_out, newv);
    end
    if (len_err !== 1'b0) begin
      bad++; $display("FAIL frame_len_err got=%b exp=0", len_err);
    end
    if (shift_count !== '0) begin
      bad++; $display("FAIL frame_cnt got=%0d exp=0", shift_count);
    end
  endtask

  task automatic test_capture_shift();
    logic [L-1:0] exp_seq = 8'b1000_0001;
    step(1, 0, 0, 0, 0, 8'h81);
    for (int i = 0; i < L; i++) begin
      total++;
      if (data_out !== exp_seq[i]) begin
        bad++;
        $display("FAIL cap_seq[%0d] got=%b exp=%b", i, data_out, exp_seq[i]);
      end
      step(0, 0, 1, 0, 0, '0);
    end
    total++;
    if (shift_count !== CW'(8)) begin
      bad++; $display("FAIL cap_cnt got=%0d exp=8", shift_count);
    end
  endtask

  task automatic test_length();
    logic [L-1:0] held;
    step(1, 0, 0, 0, 0, 8'h96);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, i[0], '0);
    held = bit_out;
    step(0, 1, 0, 0, 0, '0);
    total += 3;
    if (bit_out !== held) begin
      bad++; $display("FAIL len7_bit_out got=%h exp=%h", bit_out, held);
    end
    if (len_err !== 1'b1) begin
      bad++; $display("FAIL len7_err got=%b exp=1", len_err);
    end
    if (bit_out1 !== m1_bout) begin
      bad++; $display("FAIL lax_bit_out got=%h exp=%h", bit_out1, m1_bout);
    end
    step(1, 0, 0, 0, 0, 8'h0F);
    total++;
    if (len_err !== 1'b0) begin
      bad++; $display("FAIL len_clear got=%b exp=0", len_err);
    end
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 1, '0);
    total++;
    if (shift_count !== CW'(9)) begin
      bad++; $display("FAIL len9_cnt got=%0d exp=9", shift_count);
    end
    step(0, 1, 0, 0, 0, '0);
    total += 2;
    if (bit_out !== held || len_err !== 1'b1) begin
      bad++;
      $display("FAIL len9_reject got=%h/%b exp=%h/1", bit_out, len_err, held);
    end
    if (len_err1 !== 1'b0) begin
      bad++; $display("FAIL lax_len_err got=%b exp=0", len_err1);
    end
  endtask

  task automatic test_bypass();
    logic [L-1:0] held = bit_out;
    logic [CW-1:0] hc;
    step(0, 0, 1, 0, 1, '0);
    step(0, 0, 1, 0, 0, '0);
    hc = shift_count;
    step(0, 0, 1, 1, 1, '0);
    total += 2;
    if (data_out !== 1'b1) begin
      bad++; $display("FAIL byp_out got=%b exp=1", data_out);
    end
    if (shift_count !== hc) begin
      bad++; $display("FAIL byp_cnt got=%0d exp=%0d", shift_count, hc);
    end
    bypass = 1'b0;
    #1 total++;
    if (data_out !== mq[0]) begin
      bad++; $display("FAIL byp_sr_hold got=%b exp=%b", data_out, mq[0]);
    end
    step(0, 1, 0, 1, 0, '0);
    total += 2;
    if (bit_out !== held || len_err !== 1'b1) begin
      bad++;
      $display("FAIL byp_upd got=%h/%b exp=%h/1", bit_out, len_err, held);
    end
    if (shift_count !== hc) begin
      bad++; $display("FAIL byp_upd_cnt got=%0d exp=%0d", shift_count, hc);
    end
  endtask

  task automatic test_priority();
    logic [L-1:0] held = bit_out;
    step(1, 1, 1, 0, 0, 8'hC3);
    total += 3;
    if (bit_out !== held) begin
      bad++; $display("FAIL prio_bit_out got=%h exp=%h", bit_out, held);
    end
    if (shift_count !== '0 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL prio_state got=%0d/%b exp=0/0", shift_count, len_err);
    end
    if (data_out !== 1'b1) begin
      bad++; $display("FAIL prio_out got=%b exp=1", data_out);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, '0);
    #2 reset = 1'b0;
    #1 m_reset();
    total++;
    if (bit_out !== 8'hA5 || data_out !== 1'b0 ||
        shift_count !== '0 || len_err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%b/%0d/%b exp=a5/0/0/0",
               bit_out, data_out, shift_count, len_err);
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           1'($urandom), L'($urandom));
      total++;
      if (bit_out !== m_bout || data_out !== m_dout() ||
          shift_count !== CW'(m_cnt) || len_err !== m_err ||
          bit_out1 !== m1_bout) begin
        bad++;
        $display("FAIL rand[%0d] got=%h/%b/%0d/%b/%h exp=%h/%b/%0d/%b/%h",
                 n, bit_out, data_out, shift_count, len_err, bit_out1,
                 m_bout, m_dout(), m_cnt, m_err, m1_bout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_capture_shift();
    test_length();
    test_bypass();
    test_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
